// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin resource arbiter.
// Holds the FSM state encoding, default sizing and the one-hot helper.
package arb_pkg;

  localparam int N_DEFAULT        = 4;
  localparam int HOLD_MAX_DEFAULT = 16;
  localparam int MAX_N            = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  function automatic logic [MAX_N-1:0] onehot(input logic [3:0] idx);
    logic [MAX_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_resource_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_resource_arbiter_if
  import arb_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  modport master (output req, done, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, done, output gnt, gnt_id, busy, timeout);

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority selector: first set request at or above
// i_ptr, wrapping N-1 -> 0. Reusable by any round-robin arbiter.
module rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [IDW-1:0] o_sel,
  output logic           o_valid
);

  logic [IDW-1:0] w_idx;

  // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_sel   = '0;
    o_valid = 1'b0;
    w_idx   = i_ptr;
    for (int i = 0; i < N; i++) begin
      if (!o_valid && i_req[w_idx]) begin
        o_sel   = w_idx;
        o_valid = 1'b1;
      end
      w_idx = (w_idx == IDW'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin owner arbiter for one shared datapath: registered one-hot grant,
// held until done or request drop. Define ARB_TIMEOUT_EN to bound grant length.
module rr_resource_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = N_DEFAULT,
  parameter  int HOLD_MAX = HOLD_MAX_DEFAULT,
  localparam int IDW      = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_resource_arbiter_if.slave bus
);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("rr_resource_arbiter: N must be in 2..16");
  end
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
    $error("rr_resource_arbiter: HOLD_MAX must be in 2..255");
  end

  arb_state_e     r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic           r_busy;
  logic [IDW-1:0] w_sel;
  logic           w_valid;
  logic           w_release;

  rr_pick #(.N(N)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_rr_ptr),
    .o_sel   (w_sel),
    .o_valid (w_valid)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt;
  logic       r_timeout;
  logic       w_expire;

  assign w_expire  = (r_hold_cnt == 8'(HOLD_MAX - 1));
  assign w_release = bus.done || !bus.req[r_gnt_id] || w_expire;
  assign bus.timeout = r_timeout;
`else
  assign w_release   = bus.done || !bus.req[r_gnt_id];
  assign bus.timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= 8'd0;
      r_timeout  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_gnt    <= N'(onehot(4'(w_sel)));
            r_gnt_id <= w_sel;
            r_busy   <= 1'b1;
            r_state  <= GRANT;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt <= 8'd0;
`endif
          end
        end
        GRANT: begin
          if (w_release) begin
            r_gnt    <= '0;
            r_busy   <= 1'b0;
            // Just-served owner drops to lowest priority; explicit wrap for non-power-of-2 N.
            r_rr_ptr <= (r_gnt_id == IDW'(N - 1)) ? '0 : r_gnt_id + 1'b1;
            r_state  <= RELEASE;
`ifdef ARB_TIMEOUT_EN
            r_timeout <= w_expire && !bus.done;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_hold_cnt != 8'hFF) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
`endif
        end
        RELEASE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.gnt_id = r_gnt_id;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Self-checking bench for rr_resource_arbiter: directed vector table, hand-built
// reset/timeout sequences and a randomized run against an ownership-level model.
module tb_rr_resource_arbiter;

  localparam int N        = 4;
  localparam int HOLD_MAX = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_resource_arbiter_if #(.N(N)) bus ();

  rr_resource_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
  } vec_t;

  // Ownership-level reference: who owns, who is next in line, turnaround pending.
  int         m_owner;
  int         m_last;
  int         m_next;
  bit         m_turn;
  int         m_held;
  bit         m_tmo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req  = '0;
    bus.done = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_next  = 0;
    m_turn  = 1'b0;
    m_held  = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    m_tmo = 1'b0;
    if (m_owner >= 0) begin
      m_held++;
      if (d || !r[m_owner] || (TMO_EN && m_held == HOLD_MAX)) begin
        m_tmo   = TMO_EN && (m_held == HOLD_MAX) && !d;
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
        m_turn  = 1'b1;
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
    end else if (r != 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_next + k) % N]) begin
          m_owner = (m_next + k) % N;
          m_last  = m_owner;
          m_held  = 0;
        end
      end
    end
  endtask

  vec_t vecs[38];

  initial begin
    // Reset state, then single-requester grant/done, rr_ptr advancing to 3.
    vecs[0]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[2]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[3]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[4]  = '{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};
    vecs[6]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
    // Rotation with all requesting, done one cycle after each grant.
    vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 2'd3, 1'b0};
    vecs[9]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    vecs[10] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    vecs[11] = '{4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[12] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[13] = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0};
    vecs[14] = '{4'b1111, 1'b0, 4'b0000, 2'd1, 1'b0};
    vecs[15] = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[16] = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0};
    vecs[17] = '{4'b1111, 1'b0, 4'b0000, 2'd2, 1'b0};
    vecs[18] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[19] = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0};
    vecs[20] = '{4'b1111, 1'b0, 4'b0000, 2'd3, 1'b0};
    vecs[21] = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    // Withdrawal: owner 1 drops its request; next goes to 3, not 0.
    vecs[22] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    vecs[23] = '{4'b1011, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[24] = '{4'b1011, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[25] = '{4'b1011, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[26] = '{4'b1001, 1'b0, 4'b0000, 2'd1, 1'b0};
    vecs[27] = '{4'b1011, 1'b0, 4'b0000, 2'd1, 1'b0};
    vecs[28] = '{4'b1011, 1'b0, 4'b1000, 2'd3, 1'b1};
    // No preemption of owner 3 by requester 0.
    vecs[29] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[30] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[31] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[32] = '{4'b1001, 1'b1, 4'b0000, 2'd3, 1'b0};
    vecs[33] = '{4'b0001, 1'b0, 4'b0000, 2'd3, 1'b0};
    vecs[34] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
    // done and request drop together, then done while idle.
    vecs[35] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
    vecs[36] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[37] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};

    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", 32'(bus.gnt), 32'h0);
    check("reset_gnt_id", 32'(bus.gnt_id), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_timeout", 32'(bus.timeout), 32'h0);
    rst = 1'b0;

    // Every grant in the table ends within HOLD_MAX cycles, so timeout stays low in both builds.
    for (int i = 0; i < 38; i++) begin
      cycle(vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_gnt_id", i), 32'(bus.gnt_id), 32'(vecs[i].gnt_id));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_timeout", i), 32'(bus.timeout), 32'h0);
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    cycle(4'b0100, 1'b0);
    check("pre_rst_gnt", 32'(bus.gnt), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("async_rst_gnt", 32'(bus.gnt), 32'h0);
    check("async_rst_busy", 32'(bus.busy), 32'h0);
    check("async_rst_gnt_id", 32'(bus.gnt_id), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(4'b0001, 1'b0);
    check("post_rst_gnt", 32'(bus.gnt), 32'h1);
    check("post_rst_gnt_id", 32'(bus.gnt_id), 32'h0);

    // Grant hold limit: owner 1 never asserts done.
    do_reset();
    cycle(4'b0010, 1'b0);
    check("hold_grant", 32'(bus.gnt), 32'h2);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c < HOLD_MAX; c++) begin
      cycle(4'b0010, 1'b0);
      check($sformatf("hold_cyc%0d_gnt", c), 32'(bus.gnt), 32'h2);
      check($sformatf("hold_cyc%0d_tmo", c), 32'(bus.timeout), 32'h0);
    end
    cycle(4'b0010, 1'b0);
    check("forced_gnt", 32'(bus.gnt), 32'h0);
    check("forced_timeout", 32'(bus.timeout), 32'h1);
    cycle(4'b0010, 1'b0);
    check("forced_timeout_pulse", 32'(bus.timeout), 32'h0);
    cycle(4'b0010, 1'b0);
    check("regrant_gnt", 32'(bus.gnt), 32'h2);
    for (int c = 1; c < HOLD_MAX; c++) cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b1);
    check("done_at_limit_gnt", 32'(bus.gnt), 32'h0);
    check("done_at_limit_timeout", 32'(bus.timeout), 32'h0);
`else
    for (int c = 0; c < 20; c++) cycle(4'b0010, 1'b0);
    check("unbounded_gnt", 32'(bus.gnt), 32'h2);
    check("unbounded_timeout", 32'(bus.timeout), 32'h0);
    cycle(4'b0010, 1'b1);
    check("unbounded_release", 32'(bus.gnt), 32'h0);
`endif

    // Randomized traffic against the ownership model.
    do_reset();
    model_reset();
    begin
      logic [3:0] r;
      logic       d;
      r = 4'b0000;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom);
        d = ($urandom_range(0, 5) == 0);
        cycle(r, d);
        model_step(r, d);
        check("rand_gnt", 32'(bus.gnt), (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0);
        check("rand_gnt_id", 32'(bus.gnt_id), 32'(m_last));
        check("rand_busy", 32'(bus.busy), 32'(m_owner >= 0));
        check("rand_timeout", 32'(bus.timeout), 32'(m_tmo));
        check("rand_onehot", 32'($countones(bus.gnt) <= 1), 32'h1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_resource_arbiter.md
Name: rr_resource_arbiter

Overview:
- Sequential round-robin arbiter that shares one ALU/datapath resource among N requesters.
- Sits in front of the shared datapath and issues a registered one-hot grant plus an encoded grant index.
- The owner holds the grant until it signals done or drops its request.
- Replaces ad-hoc combinational priority encoding with fair, stateful ownership.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- IDW, $clog2(N), width of the encoded grant index; derived, not overridden.
- HOLD_MAX, 16, maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i high means requester i wants the resource.
- done  input  1  owner finished; sampled only while busy=1.
- gnt  output  N  registered one-hot grant; all zero when idle.
- gnt_id  output  IDW  index of the current or most recent owner.
- busy  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on a forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: gnt=0, gnt_id=0, busy=0, timeout=0.
  - Internal: state=IDLE, rr_ptr=0, hold_cnt=0.
  - Reset asserted mid-grant drops gnt and busy asynchronously; no done is required afterwards.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req!=0, select the first set bit scanning upward from rr_ptr, wrapping N-1 -> 0.
  - Next edge: gnt=onehot(sel), gnt_id=sel, busy=1, state=GRANT.
  - Latency from req sampled high to gnt high is exactly 1 cycle.
- GRANT:
  - gnt and gnt_id are held stable.
  - Release condition: done=1, OR req[gnt_id]=0, OR (ARB_TIMEOUT_EN only) hold_cnt==HOLD_MAX-1.
  - On release, next edge: gnt=0, busy=0, rr_ptr=(gnt_id+1) mod N, state=RELEASE.
  - gnt_id retains the last owner.
  - Requests from other requesters are ignored while in GRANT; there is no preemption.
- RELEASE:
  - Fixed one-cycle bus turnaround; always goes to IDLE next edge.
  - Consequence: minimum gap between consecutive grants is 2 cycles of gnt=0 (RELEASE plus the IDLE arbitration cycle).
- Fairness:
  - The just-served requester has the lowest priority next round.
  - With all N requesting continuously, grants rotate 0,1,...,N-1,0 with no starvation.
- done while busy=0 is ignored. done and req drop in the same cycle count as a single normal release.
- gnt is always one-hot or zero; never more than one bit set.
- Arithmetic:
  - rr_ptr wrap uses explicit compare-to-(N-1); no reliance on power-of-2 N.
  - hold_cnt is 8 bits and saturates; it is cleared on every entry to GRANT.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt increments every GRANT cycle.
  - At hold_cnt==HOLD_MAX-1 without done, the grant is force-released and timeout pulses high for the cycle gnt falls.
  - If done and timeout coincide, the release is treated as normal and timeout stays 0.
- Undefined:
  - No counter logic is built; grant hold is unbounded.
  - timeout is tied to 0 and the HOLD_MAX parameter is unused.

Decomposition:
- Shared package arb_pkg holds:
  - state enum {IDLE, GRANT, RELEASE} with 2-bit encoding.
  - localparam defaults for N and HOLD_MAX.
  - function onehot(idx).
- One sub-module is natural: rr_pick, a combinational rotating priority selector.
  - Inputs: req, rr_ptr.
  - Outputs: sel index and a valid flag.
  - It replaces any fixed priority encoder in the datapath and is reusable by other arbiters.

Test Plan:
- Reset mid-grant: grant 2 active, assert rst between clock edges -> gnt=0000 and busy=0 immediately. After release, req=0001 -> gnt=0001 one cycle later.
- Single requester: req=0100 at cycle 0 -> gnt=0100, gnt_id=2, busy=1 at cycle 1. done at cycle 4 -> gnt=0000 at cycle 5. rr_ptr=3.
- Rotation: req=1111 held, each owner pulses done one cycle after its grant -> grant sequence 0001,0010,0100,1000,0001. Each grant is separated by 2 zero cycles.
- Request withdrawal: owner 1 drops req[1] while req=1011 otherwise held -> release next edge; next grant goes to index 3, not 0.
- No preemption: owner 3 granted, then req[0] asserted -> gnt stays 1000 until done. After release, the next grant is 0001.
- ARB_TIMEOUT_EN with HOLD_MAX=4: owner never asserts done -> gnt falls after exactly 4 GRANT cycles with timeout=1 for one cycle. Repeat with done on the 4th cycle -> timeout stays 0.
